// File: rtl/writeback_arbiter.sv
// Writeback FIFO between the ALU/load producers and the register file write port.
// Loads take fixed priority; entries drain in order one per cycle with a pending-register mask.
module writeback_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_dest,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_dest,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  output logic                 write,
  output logic [ADDR_W-1:0]    write_select,
  output logic [DATA_W-1:0]    inputReg,
  output logic [2**ADDR_W-1:0] pending,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop;
  logic [ADDR_W-1:0] push_dest;
  logic [DATA_W-1:0] push_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Readiness is judged before this edge's pop, so a full FIFO never passes through.
  assign mem_ready = reset & ~full;
  assign alu_ready = reset & ~full & ~mem_valid;

  assign push      = (mem_valid & mem_ready) | (alu_valid & alu_ready);
  assign push_dest = mem_valid ? mem_dest : alu_dest;
  assign push_data = mem_valid ? mem_data : alu_data;
  assign pop       = ~empty;

  assign write        = ~empty;
  assign write_select = empty ? '0 : dest_q[head_q];
  assign inputReg     = empty ? '0 : data_q[head_q];

  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i]) pending[dest_q[i]] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        dest_q[tail_q] <= push_dest;
        data_q[tail_q] <= push_data;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and random stimulus for writeback_arbiter, checked against a queue-based model.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [3:0]  alu_dest = '0, mem_dest = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, write, full, empty;
  logic [3:0]  write_select;
  logic [15:0] inputReg, pending;
  logic [2:0]  count;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .write(write), .write_select(write_select), .inputReg(inputReg),
    .pending(pending), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  d;
    logic [15:0] v;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mrf[16];
  logic [15:0] dut_rf[16];
  int          total = 0, bad = 0, commits = 0, maxc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model.
  task automatic step();
    logic [15:0] ep;
    int          sz;
    @(negedge clk);
    sz = mq.size();
    ep = '0;
    foreach (mq[i]) ep |= 16'(1) << mq[i].d;
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("write", 32'(write), 32'(sz != 0));
    chk("wsel", 32'(write_select), sz != 0 ? 32'(mq[0].d) : 32'd0);
    chk("wdata", 32'(inputReg), sz != 0 ? 32'(mq[0].v) : 32'd0);
    chk("pending", 32'(pending), 32'(ep));
    chk("mem_ready", 32'(mem_ready), 32'(sz < DEPTH));
    chk("alu_ready", 32'(alu_ready), 32'(sz < DEPTH && !mem_valid));
    if (int'(count) > maxc) maxc = int'(count);
    if (write === 1'b1) begin
      dut_rf[write_select] = inputReg;
      commits++;
    end
    if (sz != 0) begin
      mrf[mq[0].d] = mq[0].v;
      void'(mq.pop_front());
    end
    if (sz < DEPTH) begin
      if (mem_valid)      mq.push_back('{d: mem_dest, v: mem_data});
      else if (alu_valid) mq.push_back('{d: alu_dest, v: alu_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int next;
    for (int i = 0; i < 16; i++) begin
      mrf[i] = '0;
      dut_rf[i] = '0;
    end

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    reset = 1'b1;
    idle(1);

    // Single ALU write
    alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 16'hBEEF;
    step();
    idle(3);
    chk("single_rf3", 32'(dut_rf[3]), 32'h0000BEEF);

    // Producer conflict: load wins, ALU waits one cycle
    mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 16'h1234;
    alu_valid = 1'b1; alu_dest = 4'd6; alu_data = 16'h5678;
    step();
    mem_valid = 1'b0;
    step();
    idle(4);
    chk("conf_rf5", 32'(dut_rf[5]), 32'h00001234);
    chk("conf_rf6", 32'(dut_rf[6]), 32'h00005678);

    // Stream of six loads after one ALU entry, crossing pointer wrap
    alu_valid = 1'b1; alu_dest = 4'd9; alu_data = 16'h0909;
    step();
    alu_valid = 1'b0;
    next = 0;
    for (int c = 0; c < 40 && next < 6; c++) begin
      mem_valid = 1'b1; mem_dest = 4'(next); mem_data = 16'hA000 + 16'(next);
      if (mq.size() < DEPTH) next++;
      step();
    end
    chk("wrap_all_accepted", 32'(next), 32'd6);
    idle(6);
    for (int i = 0; i < 6; i++) chk("wrap_rf", 32'(dut_rf[i]), 32'hA000 + 32'(i));
    chk("max_count", 32'(maxc <= DEPTH), 32'd1);

    // Same-destination back-to-back writes
    alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 16'h0001;
    step();
    alu_data = 16'h0002;
    step();
    idle(4);
    chk("same_rf7", 32'(dut_rf[7]), 32'h00000002);

    // Reset in the middle of a stream
    alu_valid = 1'b1; alu_dest = 4'd12; alu_data = 16'hC0C0;
    step();
    alu_dest = 4'd13; alu_data = 16'hD0D0;
    step();
    alu_dest = 4'd14; alu_data = 16'hE0E0;
    step();
    alu_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_write", 32'(write), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_pending", 32'(pending), 32'd0);
    chk("mid_ready", 32'({alu_ready, mem_ready}), 32'd0);
    mq.delete();
    #2 reset = 1'b1;
    commits = 0;
    idle(4);
    chk("mid_no_commit", 32'(commits), 32'd0);

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      mem_valid = ($urandom_range(0, 2) == 0);
      alu_valid = ($urandom_range(0, 1) == 0);
      mem_dest  = 4'($urandom_range(0, 15));
      alu_dest  = 4'($urandom_range(0, 15));
      mem_data  = 16'($urandom);
      alu_data  = 16'($urandom);
      step();
    end
    idle(6);
    for (int i = 0; i < 16; i++) chk("rand_rf", 32'(dut_rf[i]), 32'(mrf[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
